// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_port_arbiter
//  Purpose  : Shares one single-ported memory between fetch and data access.
//  Revision : 1.0  initial release
// ============================================================================
module mem_port_arbiter #(
   parameter int XLEN   = 32,
   parameter int ADDR_W = 32
) (
   input  logic                clk,
   input  logic                reset,
   // fetch port
   input  logic                if_req,
   input  logic [ADDR_W-1:0]   if_addr,
   output logic [XLEN-1:0]     if_rdata,
   output logic                if_valid,
   // data port
   input  logic                dm_req,
   input  logic                dm_we,
   input  logic [ADDR_W-1:0]   dm_addr,
   input  logic [XLEN-1:0]     dm_wdata,
   input  logic [XLEN/8-1:0]   dm_wmask,
   output logic [XLEN-1:0]     dm_rdata,
   output logic                dm_valid,
   // pipeline control
   input  logic                flush,
   output logic                stall_req,
   // memory side
   output logic                mem_req,
   output logic                mem_we,
   output logic [ADDR_W-1:0]   mem_addr,
   output logic [XLEN-1:0]     mem_wdata,
   output logic [XLEN/8-1:0]   mem_wmask,
   input  logic [XLEN-1:0]     mem_rdata,
   input  logic                mem_ready
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY_D = 2'd1,
      BUSY_F = 2'd2,
      DONE   = 2'd3
   } state_t;

   state_t              r_state;
   logic                r_fetch_kill;
   logic                r_mem_req;
   logic                r_mem_we;
   logic [ADDR_W-1:0]   r_mem_addr;
   logic [XLEN-1:0]     r_mem_wdata;
   logic [XLEN/8-1:0]   r_mem_wmask;
   logic [XLEN-1:0]     r_if_rdata;
   logic [XLEN-1:0]     r_dm_rdata;
   logic                r_if_valid;
   logic                r_dm_valid;

   logic                w_fetch_drop;
   logic                w_if_valid;

   // A fetch result is dropped if it was killed earlier or a flush lands on its last cycle.
   assign w_fetch_drop = r_fetch_kill | flush;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_fetch_kill <= 1'b0;
         r_mem_req    <= 1'b0;
         r_mem_we     <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_mem_wmask  <= '0;
         r_if_rdata   <= '0;
         r_dm_rdata   <= '0;
         r_if_valid   <= 1'b0;
         r_dm_valid   <= 1'b0;
      end else begin
         r_if_valid <= 1'b0;
         r_dm_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (dm_req) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= dm_we;
                  r_mem_addr  <= dm_addr;
                  r_mem_wdata <= dm_wdata;
                  r_mem_wmask <= dm_wmask;
                  r_state     <= BUSY_D;
               end else if (if_req && !flush) begin
                  r_mem_req   <= 1'b1;
                  r_mem_we    <= 1'b0;
                  r_mem_addr  <= if_addr;
                  r_mem_wmask <= '0;
                  r_state     <= BUSY_F;
               end
            end
            BUSY_D: begin
               if (mem_ready) begin
                  if (!r_mem_we) begin
                     r_dm_rdata <= mem_rdata;
                  end
                  r_dm_valid <= 1'b1;
                  r_mem_req  <= 1'b0;
                  r_state    <= DONE;
               end
            end
            BUSY_F: begin
               if (flush) begin
                  r_fetch_kill <= 1'b1;
               end
               if (mem_ready) begin
                  if (!w_fetch_drop) begin
                     r_if_rdata <= mem_rdata;
                     r_if_valid <= 1'b1;
                  end
                  r_fetch_kill <= 1'b0;
                  r_mem_req    <= 1'b0;
                  r_state      <= DONE;
               end
            end
            DONE: begin
               // No grant here, so a request still held for the port just served is not reissued.
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

   // A flush in the completion cycle still cancels the fetch pulse.
   assign w_if_valid = r_if_valid & ~flush;

   assign if_valid  = w_if_valid;
   assign if_rdata  = r_if_rdata;
   assign dm_valid  = r_dm_valid;
   assign dm_rdata  = r_dm_rdata;
   assign mem_req   = r_mem_req;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign mem_wmask = r_mem_wmask;

   assign stall_req = (if_req & ~w_if_valid & ~flush) | (dm_req & ~r_dm_valid);

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_port_arbiter
//  Purpose  : Randomized self-checking bench with a transaction-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_port_arbiter;

   localparam int XLEN   = 32;
   localparam int ADDR_W = 32;

   logic              clk = 1'b0;
   logic              reset;
   logic              if_req;
   logic [ADDR_W-1:0] if_addr;
   logic [XLEN-1:0]   if_rdata;
   logic              if_valid;
   logic              dm_req;
   logic              dm_we;
   logic [ADDR_W-1:0] dm_addr;
   logic [XLEN-1:0]   dm_wdata;
   logic [XLEN/8-1:0] dm_wmask;
   logic [XLEN-1:0]   dm_rdata;
   logic              dm_valid;
   logic              flush;
   logic              stall_req;
   logic              mem_req;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [XLEN-1:0]   mem_wdata;
   logic [XLEN/8-1:0] mem_wmask;
   logic [XLEN-1:0]   mem_rdata;
   logic              mem_ready;

   mem_port_arbiter #(.XLEN(XLEN), .ADDR_W(ADDR_W)) u_dut (
      .clk(clk), .reset(reset),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
      .dm_wmask(dm_wmask), .dm_rdata(dm_rdata), .dm_valid(dm_valid),
      .flush(flush), .stall_req(stall_req),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_wmask(mem_wmask), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level reference: one access owns the memory, then one completion cycle.
   bit              t_in_access, t_finishing, t_fetch, t_we, t_killed;
   logic [ADDR_W-1:0] t_addr;
   logic [XLEN-1:0]   t_wdata;
   logic [XLEN/8-1:0] t_wmask;
   logic [XLEN-1:0]   e_if_rdata, e_dm_rdata;
   bit              e_if_vraw, e_dm_valid;

   bit prev_dmv, prev_ifv, prev_flush;
   int quiet;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s at %0t: got %h expected %h", tag, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      t_in_access = 0; t_finishing = 0; t_fetch = 0; t_we = 0; t_killed = 0;
      t_addr = '0; t_wdata = '0; t_wmask = '0;
      e_if_rdata = '0; e_dm_rdata = '0; e_if_vraw = 0; e_dm_valid = 0;
   endtask

   // Advance one clock: inputs present before the edge decide what the edge does.
   task automatic tick();
      logic p_dm_req, p_dm_we, p_if_req, p_flush, p_ready;
      logic [ADDR_W-1:0] p_dm_addr, p_if_addr;
      logic [XLEN-1:0] p_wdata, p_rdata;
      logic [XLEN/8-1:0] p_wmask;
      p_dm_req = dm_req; p_dm_we = dm_we; p_dm_addr = dm_addr; p_wdata = dm_wdata;
      p_wmask = dm_wmask; p_if_req = if_req; p_if_addr = if_addr; p_flush = flush;
      p_ready = mem_ready; p_rdata = mem_rdata;
      @(posedge clk);
      #1;
      e_if_vraw = 0;
      e_dm_valid = 0;
      if (t_in_access) begin
         if (p_flush && t_fetch) t_killed = 1;
         if (p_ready) begin
            if (t_fetch) begin
               if (!t_killed) begin
                  e_if_rdata = p_rdata;
                  e_if_vraw  = 1;
               end
            end else begin
               if (!t_we) e_dm_rdata = p_rdata;
               e_dm_valid = 1;
            end
            t_in_access = 0;
            t_finishing = 1;
         end
      end else if (t_finishing) begin
         t_finishing = 0;
      end else if (p_dm_req) begin
         t_in_access = 1; t_fetch = 0; t_killed = 0; t_we = p_dm_we;
         t_addr = p_dm_addr; t_wdata = p_wdata; t_wmask = p_wmask;
      end else if (p_if_req && !p_flush) begin
         t_in_access = 1; t_fetch = 1; t_killed = 0; t_we = 0;
         t_addr = p_if_addr; t_wmask = '0;
      end
   endtask

   task automatic check_all();
      bit exp_ifv;
      exp_ifv = e_if_vraw & ~flush;
      check("mem_req",   mem_req,   t_in_access);
      check("mem_we",    mem_we,    t_we);
      check("mem_addr",  mem_addr,  t_addr);
      check("mem_wdata", mem_wdata, t_wdata);
      check("mem_wmask", mem_wmask, t_wmask);
      check("if_valid",  if_valid,  exp_ifv);
      check("dm_valid",  dm_valid,  e_dm_valid);
      check("if_rdata",  if_rdata,  e_if_rdata);
      check("dm_rdata",  dm_rdata,  e_dm_rdata);
      check("stall_req", stall_req, (if_req & ~exp_ifv & ~flush) | (dm_req & ~e_dm_valid));
   endtask

   task automatic mid_reset();
      #2;
      reset = 1'b1;
      #1;
      model_reset();
      check("rst_mem_req",  mem_req,  1'b0);
      check("rst_dm_valid", dm_valid, 1'b0);
      dm_req = 0; if_req = 0; flush = 0;
      #1;
      check_all();
      @(posedge clk);
      @(posedge clk);
      #3;
      reset = 1'b0;
      prev_dmv = 0; prev_ifv = 0; prev_flush = 0;
      quiet = 4;
   endtask

   initial begin
      int rst_at;
      int n_rst;
      reset = 1'b1;
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
      dm_wdata = '0; dm_wmask = '0; flush = 0; mem_rdata = '0; mem_ready = 0;
      model_reset();
      #12;
      check_all();
      #10;
      reset = 1'b0;

      // Zero-wait load of 0xDEADBEEF from 0x100.
      dm_req = 1; dm_we = 0; dm_addr = 32'h100; mem_ready = 1; mem_rdata = 32'hDEADBEEF;
      #1; check_all(); check("zw_stall0", stall_req, 1'b1);
      tick();
      #1; check_all();
      check("zw_memreq", mem_req, 1'b1);
      check("zw_addr",   mem_addr, 32'h100);
      check("zw_stall1", stall_req, 1'b1);
      tick();
      #1; check_all();
      check("zw_valid", dm_valid, 1'b1);
      check("zw_rdata", dm_rdata, 32'hDEADBEEF);
      check("zw_stall2", stall_req, 1'b0);
      dm_req = 0;
      tick();

      prev_dmv = 0; prev_ifv = 0; prev_flush = 0; quiet = 0;
      rst_at = 600; n_rst = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         if (!(dm_req && !prev_dmv)) begin
            dm_req   = (quiet == 0) && ($urandom_range(3) == 0);
            dm_we    = $urandom_range(1);
            dm_addr  = $urandom & 32'h0000_FFFC;
            dm_wdata = $urandom;
            dm_wmask = $urandom_range(15);
         end
         if (!(if_req && !prev_ifv && !prev_flush)) begin
            if_req  = (quiet == 0) && ($urandom_range(2) != 0);
            if_addr = $urandom & 32'h0000_FFFC;
         end
         flush     = (quiet == 0) && ($urandom_range(9) == 0);
         mem_ready = ($urandom_range(2) != 0);
         mem_rdata = $urandom;
         #1;
         check_all();
         prev_dmv   = e_dm_valid;
         prev_ifv   = e_if_vraw & ~flush;
         prev_flush = flush;
         tick();
         if (quiet > 0) quiet--;
         if (cyc >= rst_at && n_rst < 3 && t_in_access && !t_fetch) begin
            mid_reset();
            n_rst++;
            rst_at = cyc + 900;
         end
      end
      if (n_rst == 0) begin
         check("rst_exercised", 64'(n_rst), 64'd1);
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
